// File: rtl/common_pkg.sv
// Shared encodings for the per-CPU coherence agent and its tag store.
package common;

   // MSI block-state encodings shared with the bus controller.
   localparam logic [1:0] ST_M = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_I = 2'b10;

   // Bus request latched by the agent while a miss or upgrade is outstanding.
   typedef enum logic [1:0] {
      OP_RD_MISS,
      OP_WR_MISS,
      OP_INV
   } op_e;

   // Agent transaction FSM.
   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL
   } agent_state_e;

endpackage

// File: rtl/coherence_tag_store.sv
// Tag and MSI state array for a direct-mapped data cache. Two combinational
// read ports (CPU side, snoop side) and one prioritized update path:
// fill > snoop invalidate > snoop downgrade when they target the same line.
module coherence_tag_store
   import common::*;
#(
   parameter int ADDR_W = 13,
   parameter int IDX_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IDX_W-1:0]        cpu_idx,
   output logic [ADDR_W-IDX_W-1:0] cpu_tag,
   output logic [1:0]              cpu_state,
   input  logic [IDX_W-1:0]        snp_idx,
   output logic [ADDR_W-IDX_W-1:0] snp_tag,
   output logic [1:0]              snp_state,
   input  logic                    fill_en,
   input  logic [IDX_W-1:0]        fill_idx,
   input  logic [ADDR_W-IDX_W-1:0] fill_tag,
   input  logic [1:0]              fill_state,
   input  logic                    snp_inv_en,
   input  logic                    snp_dn_en
);

   localparam int TAG_W     = ADDR_W - IDX_W;
   localparam int NUM_LINES = 2 ** IDX_W;

   logic [TAG_W-1:0] tag_q   [NUM_LINES];
   logic [1:0]       state_q [NUM_LINES];

   assign cpu_tag   = tag_q[cpu_idx];
   assign cpu_state = state_q[cpu_idx];
   assign snp_tag   = tag_q[snp_idx];
   assign snp_state = state_q[snp_idx];

   // Per-line update: a completing fill overrides any snoop on the same line.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this array is small and its contents are architectural (a stale
         // tag with a non-I state would fake a hit), so it is reset explicitly
         // rather than left to power-up values like a plain data RAM.
         for (int i = 0; i < NUM_LINES; i++) begin
            tag_q[i]   <= '0;
            state_q[i] <= ST_I;
         end
      end else begin
         for (int i = 0; i < NUM_LINES; i++) begin
            if (fill_en && fill_idx == IDX_W'(i)) begin
               tag_q[i]   <= fill_tag;
               state_q[i] <= fill_state;
            end else if (snp_inv_en && snp_idx == IDX_W'(i)) begin
               state_q[i] <= ST_I;
            end else if (snp_dn_en && snp_idx == IDX_W'(i)) begin
               state_q[i] <= ST_S;
            end
         end
      end
   end

endmodule

// File: rtl/coherence_agent.sv
// Per-CPU snooping bus agent: classifies CPU accesses as hits or bus
// requests, holds the request until granted, waits out the fill, and
// answers search / invalidate snoops against its own tag store.
module coherence_agent
   import common::*;
#(
   parameter int ADDR_W      = 13,
   parameter int IDX_W       = 3,
   parameter int FILL_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              stall,
   output logic              read_miss,
   output logic              write_miss,
   output logic              invalidate,
   output logic [ADDR_W-1:0] BICO,
   output logic [1:0]        block_state,
   input  logic              grant,
   input  logic              search,
   input  logic              inv_from_other,
   input  logic [ADDR_W-1:0] BOCI,
   output logic              search_found
);

   localparam int TAG_W = ADDR_W - IDX_W;

   agent_state_e      state_q, state_n;
   op_e               op_q, op_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [3:0]        cnt_q, cnt_n;

   logic [ADDR_W-1:0] look_addr;
   logic [TAG_W-1:0]  cpu_tag, snp_tag;
   logic [1:0]        cpu_state, snp_state, line_state, fill_state;
   logic              access, hit, fill_en, snp_hit;

   // In IDLE the CPU address is looked up; afterwards the latched one.
   assign look_addr  = (state_q == IDLE) ? cpu_addr : addr_q;
   assign line_state = (cpu_tag == look_addr[ADDR_W-1:IDX_W]) ? cpu_state : ST_I;
   assign access     = cpu_rd | cpu_wr;
   assign hit        = cpu_rd ? (line_state == ST_S || line_state == ST_M)
                              : (line_state == ST_M);

   assign snp_hit    = (snp_tag == BOCI[ADDR_W-1:IDX_W]) && (snp_state != ST_I);
   assign BICO       = addr_q;

   coherence_tag_store #(
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W)
   ) u_tags (
      .clk        (clk),
      .rst        (rst),
      .cpu_idx    (look_addr[IDX_W-1:0]),
      .cpu_tag    (cpu_tag),
      .cpu_state  (cpu_state),
      .snp_idx    (BOCI[IDX_W-1:0]),
      .snp_tag    (snp_tag),
      .snp_state  (snp_state),
      .fill_en    (fill_en),
      .fill_idx   (addr_q[IDX_W-1:0]),
      .fill_tag   (addr_q[ADDR_W-1:IDX_W]),
      .fill_state (fill_state),
      .snp_inv_en (inv_from_other && snp_hit),
      .snp_dn_en  (search && snp_hit && snp_state == ST_M)
   );

   // Next-state and bus/CPU outputs for the IDLE -> REQ -> FILL transaction.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_n     = state_q;
      op_n        = op_q;
      addr_n      = addr_q;
      cnt_n       = cnt_q;
      stall       = 1'b0;
      read_miss   = 1'b0;
      write_miss  = 1'b0;
      invalidate  = 1'b0;
      block_state = 2'b00;
      fill_en     = 1'b0;
      fill_state  = ST_S;
      case (state_q)
         IDLE: begin
            if (access && !hit) begin
               stall   = 1'b1;
               addr_n  = cpu_addr;
               state_n = REQ;
               if (cpu_rd)                  op_n = OP_RD_MISS;
               else if (line_state == ST_S) op_n = OP_INV;
               else                         op_n = OP_WR_MISS;
            end
         end
         REQ: begin
            stall       = 1'b1;
            block_state = line_state;
            case (op_q)
               OP_RD_MISS: read_miss  = 1'b1;
               OP_WR_MISS: write_miss = 1'b1;
               default:    invalidate = 1'b1;
            endcase
            // Losing the shared copy before grant turns the upgrade into a full write miss.
            if (op_q == OP_INV && inv_from_other && BOCI == addr_q)
               op_n = OP_WR_MISS;
            if (grant) begin
               state_n = FILL;
               cnt_n   = 4'(FILL_CYCLES - 1);
            end
         end
         FILL: begin
            stall = 1'b1;
            if (cnt_q == 4'd0) begin
               fill_en    = 1'b1;
               fill_state = (op_q == OP_RD_MISS) ? ST_S : ST_M;
               state_n    = IDLE;
            end else begin
               cnt_n = cnt_q - 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register and registered snoop response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         op_q         <= OP_RD_MISS;
         addr_q       <= '0;
         cnt_q        <= '0;
         search_found <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values, independent of statement order.
         state_q      <= state_n;
         op_q         <= op_n;
         addr_q       <= addr_n;
         cnt_q        <= cnt_n;
         search_found <= search && snp_hit;
      end
   end

endmodule

// File: doc/coherence_agent.md
Name: coherence_agent

Overview:
- Per-CPU bus agent between one CPU's data-cache pipeline and the shared snooping bus controller.
- Keeps the MSI state and tag store for the CPU's direct-mapped data cache.
- Classifies each CPU access as a local hit or a bus request (read miss, write miss, invalidate) and holds that request until the bus grants it.
- Answers bus snoops (search, invalidate-from-other) for its own cache. One instance per CPU.

Parameters:
- ADDR_W, 13, full word address width (matches bus BICO/BOCI).
- IDX_W, 3, index bits; NUM_LINES = 2**IDX_W; tag = ADDR_W-IDX_W bits.
- FILL_CYCLES, 4, cycles after grant until a bus transaction completes; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_rd  in  1  CPU load request, level, held until stall low
- cpu_wr  in  1  CPU store request, level, held until stall low
- cpu_addr  in  ADDR_W  CPU access address
- stall  out  1  freezes the CPU while a bus transaction is pending or in flight
- read_miss  out  1  to bus
- write_miss  out  1  to bus
- invalidate  out  1  to bus
- BICO  out  ADDR_W  address of the pending request
- block_state  out  2  state of the line at BICO
- grant  in  1  bus grant for this CPU
- search  in  1  bus asks this cache to look up BOCI
- inv_from_other  in  1  bus orders invalidation of BOCI
- BOCI  in  ADDR_W  snoop address
- search_found  out  1  snoop hit response

Behaviour:
- Shared-package encodings: M=2'b00, S=2'b01, I=2'b10.
- Reset, synchronous: every line goes to I, tags are cleared, the FSM goes to IDLE, and every output is 0. Reset mid-transaction drops the transaction with no state update.
- FSM states: IDLE, REQ, FILL.
- IDLE, access present and cpu_rd has priority if both requests are high:
  - Read with line S or M and tag match: hit, stall=0, no state change.
  - Write with line M and tag match: hit.
  - Write with line S and tag match: latch the address, set the op to INV, go to REQ.
  - Any other access (tag mismatch or line I): latch the op as RD_MISS or WR_MISS and go to REQ.
  - stall is asserted combinationally the same cycle any non-hit access is seen.
- REQ:
  - Exactly one of read_miss, write_miss or invalidate is high according to the latched op.
  - BICO holds the latched address. block_state is the current state of the indexed line, or I on tag mismatch.
  - On grant, the request output drops the next cycle, the counter loads FILL_CYCLES-1, and the FSM goes to FILL.
- FILL:
  - The counter decrements each cycle. At 0 the line is written with the latched tag and its new state, and the FSM returns to IDLE.
  - New states: RD_MISS gives S; WR_MISS and INV give M.
  - stall drops the cycle after the update, and the CPU re-presents the access, which then hits.
- Snoop:
  - search_found is registered: it is 1 in the cycle after search if the BOCI line is S or M with matching tag, otherwise 0.
  - The same cycle, a snooped M line downgrades to S.
  - inv_from_other with a tag match sets the line to I at the next edge. A mismatch does nothing.
- Snoop versus own request:
  - A snoop update to the same line as a fill completing in the same cycle: the fill wins, because the bus serializes and this case is a protocol error.
  - Pending INV in REQ whose line is invalidated by the other CPU: the op converts to WR_MISS the cycle after, before grant. write_miss then asserts and block_state reads I.
- grant while in IDLE or FILL is ignored.

Decomposition:
- Shared package common holds:
  - the block-state encodings;
  - the agent op enum {OP_RD_MISS, OP_WR_MISS, OP_INV};
  - the agent FSM state enum.
- One sub-module, coherence_tag_store, holds the tag/state array with:
  - a combinational CPU-side lookup port;
  - a combinational snoop-side lookup port;
  - a single prioritized write port (fill > snoop invalidate > snoop downgrade).

Test Plan:
- After rst, cpu_rd addr 0x0A5 → stall=1, read_miss=1, BICO=0x0A5, block_state=I. grant pulse → read_miss=0 next cycle, stall low 4 cycles after FILL entry; re-read hits with stall=0.
- Line 0x0A5 in S, cpu_wr 0x0A5 → invalidate=1, block_state=S. After grant+fill the line is M and a repeat write hits.
- Line 0x0A5 in M, search with BOCI=0x0A5 → search_found=1 the next cycle and the line becomes S. search with BOCI=0x1A5 (same index, other tag) → search_found=0.
- Pending INV on 0x0A5, inv_from_other with BOCI=0x0A5 before grant → invalidate drops, write_miss=1 and block_state=I the next cycle. After grant+fill the line is M.
- Read miss to 0x0A5 evicting tag of 0x1A5 → tag replaced. A snoop on 0x1A5 gives search_found=0.
- rst asserted during FILL → all outputs 0 the next cycle. cpu_rd 0x0A5 afterwards misses again.
